fetch_buffered: RTL and testbench

Parametrised instruction-fetch stage for the pipelined LEGv8 core, successor to the plain PC/+4/branch-mux fetch. It owns the PC, issues single-outstanding requests to an instruction memory with variable latency, buffers returned instructions with their PCs in a DEPTH-entry queue, and presents them to decode through a valid/ready handshake. A taken branch (`PCSrc_F`) redirects the PC, flushes the queue and discards any in-flight response.

---
 rtl/fetch_buffered.sv | 140 ++++++++++++++
 tb/tb_fetch_buffered.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffered.sv
// fetch_buffered: instruction-fetch stage for the pipelined LEGv8 core.
// Owns the PC and keeps at most one request outstanding to a
// variable-latency instruction memory. Returned instructions are queued
// together with their PCs and handed to decode over valid/ready.
// A taken branch redirects the PC, flushes the queue and marks any
// in-flight response as stale.
module fetch_buffered #(
    parameter int            N        = 64,
    parameter int            ILEN     = 32,
    parameter int            DEPTH    = 4,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrc_F,
    input  logic [N-1:0]    PCBranch_F,
    output logic            imem_req_F,
    output logic [N-1:0]    imem_addr_F,
    input  logic            imem_ack_F,
    input  logic [ILEN-1:0] imem_rdata_F,
    output logic            instr_valid_D,
    output logic [ILEN-1:0] instr_D,
    output logic [N-1:0]    pc_D,
    input  logic            instr_ready_D
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pc_q, pc_d;
    logic [N-1:0]   pc_req_q, pc_req_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic [N-1:0]    queue_pc_q    [DEPTH];
    logic [ILEN-1:0] queue_instr_q [DEPTH];

    logic push;
    logic pop;

    // A request is only issued when the queue has room for its response,
    // so a push can never overflow; a redirect cycle suppresses the
    // request because the PC is about to change.
    assign imem_req_F    = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !PCSrc_F && reset;
    assign imem_addr_F   = pc_q;
    assign instr_valid_D = (count_q != '0);
    assign instr_D       = queue_instr_q[rd_ptr_q];
    assign pc_D          = queue_pc_q[rd_ptr_q];
    assign pop           = instr_valid_D && instr_ready_D;

    // Next-state: request FSM, PC update, queue pointers; a redirect overrides all queue activity.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_req_d = pc_req_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push     = 1'b0;

        case (state_q)
            IDLE: begin
                if (imem_req_F) begin
                    pc_req_d = pc_q;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (imem_ack_F && !PCSrc_F) begin
                    push    = 1'b1;
                    pc_d    = pc_req_q + N'(4);
                    state_d = IDLE;
                end else if (PCSrc_F) begin
                    state_d = imem_ack_F ? IDLE : DISCARD;
                end
            end
            DISCARD: begin
                if (imem_ack_F) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (PCSrc_F) begin
            pc_d     = PCBranch_F;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control state registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            pc_req_q <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_req_q <= pc_req_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_pc_q[wr_ptr_q]    <= pc_req_q;
            queue_instr_q[wr_ptr_q] <= imem_rdata_F;
        end
    end

endmodule

// File: tb/tb_fetch_buffered.sv
// Testbench for fetch_buffered: table of per-cycle vectors (memory
// responses, redirects, decode readiness, expected outputs) plus a
// hand-written reset-during-BUSY sequence on a second instance.
module tb_fetch_buffered;

    logic        clk;

    // Instance 1: RESET_PC = 0
    logic        reset;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic        imem_req_F;
    logic [63:0] imem_addr_F;
    logic        imem_ack_F;
    logic [31:0] imem_rdata_F;
    logic        instr_valid_D;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        instr_ready_D;

    // Instance 2: RESET_PC = 0x400
    logic        reset2;
    logic        imem_req2;
    logic [63:0] imem_addr2;
    logic        imem_ack2;
    logic [31:0] imem_rdata2;
    logic        instr_valid2;
    logic [31:0] instr2;
    logic [63:0] pc2;

    int compared;
    int mismatched;

    typedef struct {
        logic        rst_n;
        logic        src;
        logic [63:0] tgt;
        logic        ack;
        logic [63:0] ack_addr;
        logic        rdy;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
    } vec_t;

    vec_t  vecs[$];
    string vnames[$];

    fetch_buffered #(.N(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .PCSrc_F      (PCSrc_F),
        .PCBranch_F   (PCBranch_F),
        .imem_req_F   (imem_req_F),
        .imem_addr_F  (imem_addr_F),
        .imem_ack_F   (imem_ack_F),
        .imem_rdata_F (imem_rdata_F),
        .instr_valid_D(instr_valid_D),
        .instr_D      (instr_D),
        .pc_D         (pc_D),
        .instr_ready_D(instr_ready_D)
    );

    fetch_buffered #(.N(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h400)) dut2 (
        .clk          (clk),
        .reset        (reset2),
        .PCSrc_F      (1'b0),
        .PCBranch_F   (64'h0),
        .imem_req_F   (imem_req2),
        .imem_addr_F  (imem_addr2),
        .imem_ack_F   (imem_ack2),
        .imem_rdata_F (imem_rdata2),
        .instr_valid_D(instr_valid2),
        .instr_D      (instr2),
        .pc_D         (pc2),
        .instr_ready_D(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the memory model returns for a given address.
    function automatic logic [31:0] instrFor(input logic [63:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    task automatic addVec(input string name, input logic rst_n, input logic src,
                          input logic [63:0] tgt, input logic ack, input logic [63:0] ack_addr,
                          input logic rdy, input logic e_req, input logic [63:0] e_addr,
                          input logic e_valid, input logic [63:0] e_pc);
        vec_t v;
        v.rst_n = rst_n; v.src = src; v.tgt = tgt; v.ack = ack; v.ack_addr = ack_addr;
        v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        vecs.push_back(v);
        vnames.push_back(name);
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the falling edge.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        reset         = v.rst_n;
        PCSrc_F       = v.src;
        PCBranch_F    = v.tgt;
        imem_ack_F    = v.ack;
        imem_rdata_F  = v.ack ? instrFor(v.ack_addr) : 32'h0;
        instr_ready_D = v.rdy;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name,
                               input logic a_req, input logic [63:0] a_addr,
                               input logic a_valid, input logic [63:0] a_pc, input logic [31:0] a_instr,
                               input logic e_req, input logic [63:0] e_addr,
                               input logic e_valid, input logic [63:0] e_pc);
        compared++;
        if (a_req !== e_req) begin
            mismatched++;
            $display("[TB] FAIL %s imem_req_F: got %0b expected %0b", name, a_req, e_req);
        end
        if (e_req) begin
            compared++;
            if (a_addr !== e_addr) begin
                mismatched++;
                $display("[TB] FAIL %s imem_addr_F: got %h expected %h", name, a_addr, e_addr);
            end
        end
        compared++;
        if (a_valid !== e_valid) begin
            mismatched++;
            $display("[TB] FAIL %s instr_valid_D: got %0b expected %0b", name, a_valid, e_valid);
        end
        if (e_valid) begin
            compared++;
            if (a_pc !== e_pc) begin
                mismatched++;
                $display("[TB] FAIL %s pc_D: got %h expected %h", name, a_pc, e_pc);
            end
            compared++;
            if (a_instr !== instrFor(e_pc)) begin
                mismatched++;
                $display("[TB] FAIL %s instr_D: got %h expected %h", name, a_instr, instrFor(e_pc));
            end
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        reset         = 1'b0;
        PCSrc_F       = 1'b0;
        PCBranch_F    = '0;
        imem_ack_F    = 1'b0;
        imem_rdata_F  = '0;
        instr_ready_D = 1'b0;
        reset2        = 1'b0;
        imem_ack2     = 1'b0;
        imem_rdata2   = '0;

        // Streaming, L=1, decode always ready
        addVec("rst_a", 0,0,0, 0,0, 1, 0,0,   0,0);
        addVec("a",     1,0,0, 0,0, 1, 1,0,   0,0);
        addVec("a",     1,0,0, 1,0, 1, 0,0,   0,0);
        addVec("a",     1,0,0, 0,0, 1, 1,4,   1,0);
        addVec("a",     1,0,0, 1,4, 1, 0,0,   0,0);
        addVec("a",     1,0,0, 0,0, 1, 1,8,   1,4);
        addVec("a",     1,0,0, 1,8, 1, 0,0,   0,0);
        addVec("a",     1,0,0, 0,0, 1, 1,'hC, 1,8);

        // Backpressure to full, single pop, wrap, push+pop at count=2
        addVec("rst_b", 0,0,0, 0,0,    0, 0,0,    0,0);
        addVec("b",     1,0,0, 0,0,    0, 1,0,    0,0);
        addVec("b",     1,0,0, 1,0,    0, 0,0,    0,0);
        addVec("b",     1,0,0, 0,0,    0, 1,4,    1,0);
        addVec("b",     1,0,0, 1,4,    0, 0,0,    1,0);
        addVec("b",     1,0,0, 0,0,    0, 1,8,    1,0);
        addVec("b",     1,0,0, 1,8,    0, 0,0,    1,0);
        addVec("b",     1,0,0, 0,0,    0, 1,'hC,  1,0);
        addVec("b",     1,0,0, 1,'hC,  0, 0,0,    1,0);
        addVec("b_full",1,0,0, 0,0,    0, 0,0,    1,0);
        addVec("b_full",1,0,0, 0,0,    0, 0,0,    1,0);
        addVec("b_pop", 1,0,0, 0,0,    1, 0,0,    1,0);
        addVec("b",     1,0,0, 0,0,    0, 1,'h10, 1,4);
        addVec("b",     1,0,0, 1,'h10, 0, 0,0,    1,4);
        addVec("b",     1,0,0, 0,0,    0, 0,0,    1,4);
        addVec("b",     1,0,0, 0,0,    1, 0,0,    1,4);
        addVec("b",     1,0,0, 0,0,    1, 1,'h14, 1,8);
        addVec("b_pp",  1,0,0, 1,'h14, 1, 0,0,    1,'hC);
        addVec("b",     1,0,0, 0,0,    0, 1,'h18, 1,'h10);
        addVec("b_pp",  1,0,0, 1,'h18, 1, 0,0,    1,'h10);
        addVec("b",     1,0,0, 0,0,    1, 1,'h1C, 1,'h14);
        addVec("b",     1,0,0, 0,0,    1, 0,0,    1,'h18);
        addVec("b",     1,0,0, 1,'h1C, 1, 0,0,    0,0);
        addVec("b",     1,0,0, 0,0,    1, 1,'h20, 1,'h1C);

        // Redirects: BUSY with L=3 (and again in DISCARD), coinciding with ack, in IDLE
        addVec("rst_c", 0,0,0,      0,0,     0, 0,0,     0,0);
        addVec("c",     1,0,0,      0,0,     0, 1,0,     0,0);
        addVec("c",     1,0,0,      0,0,     0, 0,0,     0,0);
        addVec("c",     1,0,0,      0,0,     0, 0,0,     0,0);
        addVec("c",     1,0,0,      1,0,     0, 0,0,     0,0);
        addVec("c",     1,0,0,      0,0,     0, 1,4,     1,0);
        addVec("c",     1,0,0,      0,0,     0, 0,0,     1,0);
        addVec("c",     1,0,0,      0,0,     0, 0,0,     1,0);
        addVec("c",     1,0,0,      1,4,     0, 0,0,     1,0);
        addVec("c",     1,0,0,      0,0,     0, 1,8,     1,0);
        addVec("c_br",  1,1,'h100,  0,0,     0, 0,0,     1,0);
        addVec("c_dbr", 1,1,'h180,  0,0,     0, 0,0,     0,0);
        addVec("c_stl", 1,0,0,      1,8,     0, 0,0,     0,0);
        addVec("c",     1,0,0,      0,0,     0, 1,'h180, 0,0);
        addVec("c",     1,0,0,      0,0,     0, 0,0,     0,0);
        addVec("c",     1,0,0,      0,0,     0, 0,0,     0,0);
        addVec("c",     1,0,0,      1,'h180, 0, 0,0,     0,0);
        addVec("c",     1,0,0,      0,0,     0, 1,'h184, 1,'h180);
        addVec("d_co",  1,1,'h200,  1,'h184, 0, 0,0,     1,'h180);
        addVec("d",     1,0,0,      0,0,     0, 1,'h200, 0,0);
        addVec("d",     1,0,0,      1,'h200, 0, 0,0,     0,0);
        addVec("d",     1,0,0,      0,0,     0, 1,'h204, 1,'h200);
        addVec("d",     1,0,0,      1,'h204, 0, 0,0,     1,'h200);
        addVec("d_ibr", 1,1,'h300,  0,0,     1, 0,0,     1,'h200);
        addVec("d",     1,0,0,      0,0,     0, 1,'h300, 0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("%s[%0d]", vnames[i], i),
                        imem_req_F, imem_addr_F, instr_valid_D, pc_D, instr_D,
                        vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc);
        end

        // Reset asserted while BUSY, late ack after release must be ignored
        @(posedge clk); #1; reset2 = 1'b1;
        @(negedge clk);
        checkOutput("e_first", imem_req2, imem_addr2, instr_valid2, pc2, instr2, 1, 64'h400, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("e_busy", imem_req2, imem_addr2, instr_valid2, pc2, instr2, 0, 0, 0, 0);
        @(posedge clk); #1; reset2 = 1'b0; #1;
        checkOutput("e_async", imem_req2, imem_addr2, instr_valid2, pc2, instr2, 0, 0, 0, 0);
        @(posedge clk); #1; reset2 = 1'b1; imem_ack2 = 1'b1; imem_rdata2 = 32'hBAD0_0BAD;
        @(negedge clk);
        checkOutput("e_rel", imem_req2, imem_addr2, instr_valid2, pc2, instr2, 1, 64'h400, 0, 0);
        @(posedge clk); #1; imem_ack2 = 1'b0;
        @(negedge clk);
        checkOutput("e_ign", imem_req2, imem_addr2, instr_valid2, pc2, instr2, 0, 0, 0, 0);
        @(posedge clk); #1; imem_ack2 = 1'b1; imem_rdata2 = instrFor(64'h400);
        @(negedge clk);
        checkOutput("e_ack", imem_req2, imem_addr2, instr_valid2, pc2, instr2, 0, 0, 0, 0);
        @(posedge clk); #1; imem_ack2 = 1'b0;
        @(negedge clk);
        checkOutput("e_head", imem_req2, imem_addr2, instr_valid2, pc2, instr2, 1, 64'h404, 1, 64'h400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
